// File: rtl/k_fifo2_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | k_fifo2_ctrl: pointer/handshake controller for the 2-deep dual-port RAM,   |
// | first-word-fall-through read, flush and saturating write-stall counter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module k_fifo2_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 1,
  parameter int STALL_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [DATA_SIZE-1:0] wr_data_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [DATA_SIZE-1:0] rd_data_o,
  input  logic                 flush_i,
  output logic [ADDR_SIZE:0]   count_o,
  output logic [STALL_W-1:0]   stall_cnt_o,
  input  logic                 stall_clr_i,
  output logic                 ram_wen_o,
  output logic [ADDR_SIZE-1:0] ram_waddr_o,
  output logic [ADDR_SIZE-1:0] ram_raddr_o,
  output logic [DATA_SIZE-1:0] ram_d_o,
  input  logic [DATA_SIZE-1:0] ram_q_i
);

  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_mid   = 2'd1;
  localparam logic [1:0] c_st_full  = 2'd2;

  localparam logic [ADDR_SIZE:0]   c_depth    = (ADDR_SIZE+1)'(2**ADDR_SIZE);
  localparam logic [ADDR_SIZE:0]   c_one      = (ADDR_SIZE+1)'(1);
  localparam logic [STALL_W-1:0]   c_stall_max = '1;
  localparam logic [STALL_W-1:0]   c_stall_one = STALL_W'(1);

  logic [1:0]         state_q, state_d;
  logic [ADDR_SIZE:0] wptr_q, wptr_d;
  logic [ADDR_SIZE:0] rptr_q, rptr_d;
  logic [ADDR_SIZE:0] count_q, count_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               w_push;
  logic               w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_empty;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Flush overrides any handshake; push/pop are already masked by flush.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      state_d = c_st_empty;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) wptr_d = wptr_q + c_one;
      if (w_pop)  rptr_d = rptr_q + c_one;
      if (w_push && !w_pop)      count_d = count_q + c_one;
      else if (!w_push && w_pop) count_d = count_q - c_one;
      if (count_d == '0)          state_d = c_st_empty;
      else if (count_d == c_depth) state_d = c_st_full;
      else                         state_d = c_st_mid;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_clr_i)
      stall_d = '0;
    else if (wr_valid_i && !wr_ready_o && (stall_q != c_stall_max))
      stall_d = stall_q + c_stall_one;
  end

  always_comb begin
    wr_ready_o = rst_n && (state_q != c_st_full) && !flush_i;
    rd_valid_o = (state_q != c_st_empty);
    w_push     = wr_valid_i && wr_ready_o;
    w_pop      = rd_valid_o && rd_ready_i && !flush_i;
    ram_wen_o  = w_push;
  end

  assign ram_waddr_o = wptr_q[ADDR_SIZE-1:0];
  assign ram_raddr_o = rptr_q[ADDR_SIZE-1:0];
  assign ram_d_o     = wr_data_i;
  assign rd_data_o   = ram_q_i;
  assign count_o     = count_q;
  assign stall_cnt_o = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_k_fifo2_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_k_fifo2_ctrl: directed scoreboard bench with a behavioural 2-deep RAM.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_k_fifo2_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       flush = 1'b0;
  logic [1:0] count;
  logic [7:0] stall_cnt;
  logic       stall_clr = 1'b0;
  logic       ram_wen;
  logic       ram_waddr;
  logic       ram_raddr;
  logic [7:0] ram_d;
  logic [7:0] ram_q;

  logic [7:0] mem [2];
  logic [7:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  k_fifo2_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(1), .STALL_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .flush_i(flush), .count_o(count),
    .stall_cnt_o(stall_cnt), .stall_clr_i(stall_clr),
    .ram_wen_o(ram_wen), .ram_waddr_o(ram_waddr), .ram_raddr_o(ram_raddr),
    .ram_d_o(ram_d), .ram_q_i(ram_q)
  );

  always @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_d;
  assign ram_q = mem[ram_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted read is compared against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got 0x%0h expected no word at %0t", rd_data, $time);
      end else begin
        chk("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input logic wv, input logic [7:0] wd, input logic rr,
                      input logic fl, input logic sc);
    @(posedge clk);
    #1;
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl; stall_clr = sc;
    @(negedge clk);
    if (flush) exp_q.delete();
    else if (wr_valid && wr_ready) exp_q.push_back(wr_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, fill to FULL
    #12;
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_count", {30'h0, count}, 32'h0);
    chk("rst_stall", {24'h0, stall_cnt}, 32'h0);
    chk("rst_ram_wen", {31'h0, ram_wen}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 8'hA1, 0, 0, 0);
    step(1, 8'hB2, 0, 0, 0);
    chk("t1_count1", {30'h0, count}, 32'h1);
    chk("t1_rd_data_a1", {24'h0, rd_data}, 32'hA1);
    step(0, 8'h00, 0, 0, 0);
    chk("t1_count2", {30'h0, count}, 32'h2);
    chk("t1_full_wr_ready", {31'h0, wr_ready}, 32'h0);
    chk("t1_rd_valid", {31'h0, rd_valid}, 32'h1);
    chk("t1_head", {24'h0, rd_data}, 32'hA1);

    // 2: FULL with write and read together pops only
    step(1, 8'hC3, 1, 0, 0);
    chk("t2_no_write", {31'h0, ram_wen}, 32'h0);
    step(1, 8'hC3, 0, 0, 0);
    chk("t2_count1", {30'h0, count}, 32'h1);
    chk("t2_wr_ready", {31'h0, wr_ready}, 32'h1);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("t2_empty", {30'h0, count}, 32'h0);
    chk("t2_rd_valid0", {31'h0, rd_valid}, 32'h0);

    // 3: steady push+pop at count=1, pointers wrap
    step(1, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(i), 1, 0, 0);
      chk("t3_count_steady", {30'h0, count}, 32'h1);
    end
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("t3_drained", {30'h0, count}, 32'h0);

    // 4: stall counter saturation and clear
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 8'h33, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("t4_stall_sat", {24'h0, stall_cnt}, 32'hFF);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);
    chk("t4_stall_clr", {24'h0, stall_cnt}, 32'h0);
    chk("t4_count_full", {30'h0, count}, 32'h2);

    // 5: flush beats simultaneous write/read
    step(1, 8'h44, 1, 1, 0);
    chk("t5_flush_wen", {31'h0, ram_wen}, 32'h0);
    chk("t5_flush_wr_ready", {31'h0, wr_ready}, 32'h0);
    step(0, 8'h00, 0, 0, 0);
    chk("t5_count0", {30'h0, count}, 32'h0);
    chk("t5_rd_valid0", {31'h0, rd_valid}, 32'h0);

    // 6: asynchronous reset between edges
    step(1, 8'h77, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("t6_count1", {30'h0, count}, 32'h1);
    @(posedge clk); #3 rst_n = 1'b0; wr_valid = 1'b1;
    #1;
    chk("t6_rst_wr_ready", {31'h0, wr_ready}, 32'h0);
    chk("t6_rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("t6_rst_count", {30'h0, count}, 32'h0);
    exp_q.delete();
    wr_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 8'h5A, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("t6_count_after", {30'h0, count}, 32'h1);
    chk("t6_rd_5a", {24'h0, rd_data}, 32'h5A);
    step(0, 8'h00, 0, 0, 0);
    chk("t6_empty", {30'h0, count}, 32'h0);

    chk("sb_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
